// File: rtl/adpcm_mul_pkg.sv
// Shared constants and operand extension for the ADPCM
// multiply / multiply-accumulate pipeline.
package adpcm_mul_pkg;

  localparam int DIN0_W_DEF    = 15;
  localparam int DIN1_W_DEF    = 15;
  localparam int DOUT_W_DEF    = 29;
  localparam int NUM_STAGE_DEF = 3;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

  // Widest operand or result the pipeline can be built for.
  localparam int EXT_W = 64;

  typedef logic [EXT_W-1:0] ext_t;

  // v holds a w-bit operand in its low bits; the rest is
  // filled with copies of bit w-1 when s=1, zeros otherwise.
  function automatic ext_t ext_op(
    input ext_t v,
    input int   w,
    input bit   s
  );
    ext_t t;
    t = v << (EXT_W - w);
    if (s) begin
      t = ext_t'($signed(t) >>> (EXT_W - w));
    end else begin
      t = t >> (EXT_W - w);
    end
    return t;
  endfunction

endpackage

// File: rtl/adpcm_main_mul_sreg.sv
// Clock-enabled, synchronously cleared delay line used for
// the valid / acc_clr side-band of the multiplier pipeline.
module adpcm_main_mul_sreg #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_thru
      logic w_unused;
      assign w_unused = ^{i_clk, i_reset, i_ce};
      assign o_q      = i_d;
    end else begin : g_sr
      // Newest entry in the low slice, oldest in the top one.
      logic [DEPTH*WIDTH-1:0] r_sr;
      logic [DEPTH*WIDTH-1:0] w_nxt;

      if (DEPTH == 1) begin : g_one
        assign w_nxt = i_d;
      end else begin : g_many
        assign w_nxt = {r_sr[(DEPTH-1)*WIDTH-1:0], i_d};
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_sr <= '0;
        end else if (i_ce) begin
          r_sr <= w_nxt;
        end
      end

      assign o_q = r_sr[DEPTH*WIDTH-1 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/adpcm_main_mulacc_pipe.sv
// Pipelined multiplier with optional accumulate stage,
// global clock enable and a valid side-band.
module adpcm_main_mulacc_pipe
  import adpcm_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = NUM_STAGE_DEF,
  parameter int din0_WIDTH  = DIN0_W_DEF,
  parameter int din1_WIDTH  = DIN1_W_DEF,
  parameter int dout_WIDTH  = DOUT_W_DEF,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 0,
  parameter int ACC_EN      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  vld_in,
  input  logic                  acc_clr,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  vld_out
);

  localparam int DW = dout_WIDTH;

  generate
    if (NUM_STAGE < NUM_STAGE_MIN ||
        NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
      $error("NUM_STAGE must lie in 1..6");
    end
    if (DW < 2 || DW > EXT_W - 1) begin : g_bad_dout
      $error("dout_WIDTH must lie in 2..63");
    end
    if (din0_WIDTH < 1 || din0_WIDTH > EXT_W ||
        din1_WIDTH < 1 || din1_WIDTH > EXT_W ||
        ID < 0) begin : g_bad_misc
      $error("operand width or ID out of range");
    end
  endgenerate

  ext_t w_a_ext;
  ext_t w_b_ext;

  assign w_a_ext = ext_op(ext_t'(din0), din0_WIDTH,
                          din0_SIGNED != 0);
  assign w_b_ext = ext_op(ext_t'(din1), din1_WIDTH,
                          din1_SIGNED != 0);

  // Only the low DW product bits survive truncation.
  logic w_unused;
  assign w_unused = ^{w_a_ext[EXT_W-1:DW],
                      w_b_ext[EXT_W-1:DW]};

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_mul;
  logic [DW-1:0] w_prod;

  generate
    if (NUM_STAGE == 1) begin : g_comb_in
      assign w_a = w_a_ext[DW-1:0];
      assign w_b = w_b_ext[DW-1:0];
    end else begin : g_reg_in
      logic [DW-1:0] r_a;
      logic [DW-1:0] r_b;
      always_ff @(posedge clk) begin
        if (ce) begin
          r_a <= w_a_ext[DW-1:0];
          r_b <= w_b_ext[DW-1:0];
        end
      end
      assign w_a = r_a;
      assign w_b = r_b;
    end
  endgenerate

  assign w_mul = w_a * w_b;

  generate
    if (NUM_STAGE <= 2) begin : g_no_ret
      assign w_prod = w_mul;
    end else begin : g_ret
      localparam int RT = NUM_STAGE - 2;
      logic [RT*DW-1:0] r_ret;
      logic [RT*DW-1:0] w_ret_nxt;

      if (RT == 1) begin : g_ret_one
        assign w_ret_nxt = w_mul;
      end else begin : g_ret_many
        assign w_ret_nxt = {r_ret[(RT-1)*DW-1:0], w_mul};
      end

      always_ff @(posedge clk) begin
        if (ce) begin
          r_ret <= w_ret_nxt;
        end
      end

      assign w_prod = r_ret[RT*DW-1 -: DW];
    end
  endgenerate

  logic [1:0] w_ctl_in;
  logic [1:0] w_ctl_pre;
  logic       w_vld_pre;
  logic       w_clr_pre;

  // acc_clr only rides along with a real sample in MAC mode.
  assign w_ctl_in = {vld_in & acc_clr & (ACC_EN != 0),
                     vld_in};

  adpcm_main_mul_sreg #(
    .DEPTH (NUM_STAGE - 1),
    .WIDTH (2)
  ) u_ctl (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ce    (ce),
    .i_d     (w_ctl_in),
    .o_q     (w_ctl_pre)
  );

  assign w_vld_pre = w_ctl_pre[0];
  assign w_clr_pre = w_ctl_pre[1];

  logic          r_vld;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_acc_nxt;

  assign w_acc_nxt = (ACC_EN != 0 && !w_clr_pre) ?
                     r_acc + w_prod : w_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= 1'b0;
      r_acc <= '0;
    end else if (ce) begin
      r_vld <= w_vld_pre;
      if (w_vld_pre) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

  assign dout    = r_acc;
  assign vld_out = r_vld;

endmodule

// File: tb/tb_adpcm_main_mulacc_pipe.sv
// Randomised and directed bench for adpcm_main_mulacc_pipe
// across several parameter sets.
module tb_adpcm_main_mulacc_pipe;

  localparam int N  = 5;
  localparam int DW = 29;
  localparam int LAT [N] = '{3, 3, 3, 1, 6};
  localparam bit SGN [N] = '{0, 1, 0, 1, 0};
  localparam bit ACC [N] = '{0, 0, 1, 1, 0};

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        ce      = 1'b0;
  logic        vld_in  = 1'b0;
  logic        acc_clr = 1'b0;
  logic [14:0] din0    = '0;
  logic [14:0] din1    = '0;

  logic [DW-1:0] d_dout [N];
  logic          d_vld  [N];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adpcm_main_mulacc_pipe u_uns (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in),
    .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .dout(d_dout[0]), .vld_out(d_vld[0]));

  adpcm_main_mulacc_pipe #(
    .din0_SIGNED(1), .din1_SIGNED(1)
  ) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in),
    .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .dout(d_dout[1]), .vld_out(d_vld[1]));

  adpcm_main_mulacc_pipe #(.ACC_EN(1)) u_mac (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in),
    .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .dout(d_dout[2]), .vld_out(d_vld[2]));

  adpcm_main_mulacc_pipe #(
    .NUM_STAGE(1), .ACC_EN(1),
    .din0_SIGNED(1), .din1_SIGNED(1)
  ) u_mac1 (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in),
    .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .dout(d_dout[3]), .vld_out(d_vld[3]));

  adpcm_main_mulacc_pipe #(.NUM_STAGE(6), .ID(7)) u_p6 (
    .clk(clk), .reset(reset), .ce(ce), .vld_in(vld_in),
    .acc_clr(acc_clr), .din0(din0), .din1(din1),
    .dout(d_dout[4]), .vld_out(d_vld[4]));

  // Model: history of samples indexed by ce-enabled edge.
  bit            hv [8];
  int            ha [8];
  int            hb [8];
  bit            hc [8];
  int            k = 0;
  logic [DW-1:0] e_d [N];
  bit            e_v [N];

  function automatic longint sx(input int v);
    return (v >= 16384) ? longint'(v) - 32768 : longint'(v);
  endfunction

  function automatic logic [DW-1:0] mul(
    input bit s, input int a, input int b);
    longint x;
    longint y;
    x = s ? sx(a) : longint'(a);
    y = s ? sx(b) : longint'(b);
    return DW'(x * y);
  endfunction

  initial begin
    foreach (e_d[j]) begin
      e_d[j] = '0;
      e_v[j] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      foreach (hv[i]) hv[i] = 1'b0;
      foreach (e_d[j]) begin
        e_d[j] = '0;
        e_v[j] = 1'b0;
      end
    end else if (ce) begin
      k = (k + 1) % 8;
      hv[k] = vld_in;
      ha[k] = int'(din0);
      hb[k] = int'(din1);
      hc[k] = acc_clr;
      for (int j = 0; j < N; j++) begin
        int s;
        logic [DW-1:0] p;
        s = (k + 9 - LAT[j]) % 8;
        e_v[j] = hv[s];
        if (hv[s]) begin
          p = mul(SGN[j], ha[s], hb[s]);
          e_d[j] = (ACC[j] && !hc[s]) ? DW'(e_d[j] + p) : p;
        end
      end
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < N; j++) begin
        check($sformatf("vld_out[%0d]", j),
              64'(d_vld[j]), 64'(e_v[j]));
        check($sformatf("dout[%0d]", j),
              64'(d_dout[j]), 64'(e_d[j]));
      end
    end
  end

  task automatic step(input logic r, input logic c,
                      input logic v, input logic [14:0] a,
                      input logic [14:0] b, input logic cl);
    @(negedge clk);
    reset   = r;
    ce      = c;
    vld_in  = v;
    din0    = a;
    din1    = b;
    acc_clr = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input int j,
                     input logic [DW-1:0] ed, input logic ev);
    check({nm, "_dout"}, 64'(d_dout[j]), 64'(ed));
    check({nm, "_vld"}, 64'(d_vld[j]), 64'(ev));
  endtask

  function automatic logic [14:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 15'h7FFF;
      1:       return 15'h0000;
      2:       return 15'h4000;
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(1);
    chk_en = 1'b1;
    lit("rst_uns", 0, 29'h0, 1'b0);
    lit("rst_mac", 2, 29'h0, 1'b0);

    step(0, 1, 1, 15'h7FFF, 15'h7FFF, 0);
    idle(3);
    lit("trunc_uns", 0, 29'h1FFF0001, 1'b1);
    lit("trunc_sgn", 1, 29'h0000001, 1'b1);

    step(0, 1, 1, 15'h7FFF, 15'h0003, 0);
    idle(3);
    lit("sgn_m3", 1, 29'h1FFFFFFD, 1'b1);
    lit("uns_x3", 0, 29'h0017FFD, 1'b1);

    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 1, 2, 2, 0);
    step(0, 0, 1, 7, 7, 0);
    step(0, 0, 1, 7, 7, 0);
    step(0, 1, 1, 3, 3, 0);
    lit("stall_gap", 0, 29'h0017FFD, 1'b0);
    step(0, 1, 1, 4, 4, 0);
    lit("stall_1", 0, 29'd1, 1'b1);
    idle(1);
    lit("stall_4", 0, 29'd4, 1'b1);
    idle(1);
    lit("stall_9", 0, 29'd9, 1'b1);
    idle(1);
    lit("stall_16", 0, 29'd16, 1'b1);
    idle(1);
    lit("stall_hold", 0, 29'd16, 1'b0);

    step(0, 1, 1, 2, 3, 1);
    step(0, 1, 1, 4, 5, 0);
    step(0, 1, 1, 10, 10, 0);
    step(0, 1, 1, 1, 1, 1);
    lit("mac_6", 2, 29'd6, 1'b1);
    idle(1);
    lit("mac_26", 2, 29'd26, 1'b1);
    idle(1);
    lit("mac_126", 2, 29'd126, 1'b1);
    idle(1);
    lit("mac_clr1", 2, 29'd1, 1'b1);

    step(0, 1, 1, 15'h7FFF, 15'h4000, 1);
    step(0, 1, 1, 15'h3FFF, 15'h0001, 0);
    step(0, 1, 1, 1, 1, 0);
    idle(1);
    lit("wrap_ld", 2, 29'h1FFFC000, 1'b1);
    idle(1);
    lit("wrap_max", 2, 29'h1FFFFFFF, 1'b1);
    idle(1);
    lit("wrap_zero", 2, 29'h0, 1'b1);

    step(0, 1, 1, 6, 6, 0);
    step(0, 1, 1, 8, 8, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 5, 7, 0);
    lit("mrst_uns", 0, 29'h0, 1'b0);
    lit("mrst_mac", 2, 29'h0, 1'b0);
    idle(1);
    lit("mrst_q1", 0, 29'h0, 1'b0);
    idle(1);
    lit("mrst_q2", 0, 29'h0, 1'b0);
    idle(1);
    lit("mrst_35", 0, 29'd35, 1'b1);
    lit("mrst_mac35", 2, 29'd35, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 3) != 0,
           rnd_op(), rnd_op(),
           $urandom_range(0, 4) == 0);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adpcm_main_mulacc_pipe.md
ADPCM_MAIN_MULACC_PIPE -- requirements
Module: adpcm_main_mulacc_pipe

Interface
REQ-001 The module SHALL have parameter ID, default 1, meaning instance tag with no functional effect.
REQ-002 The module SHALL have parameter NUM_STAGE, default 3, meaning pipeline latency in ce-enabled cycles, legal range 1..6.
REQ-003 The module SHALL have parameter din0_WIDTH, default 15, meaning operand 0 width.
REQ-004 The module SHALL have parameter din1_WIDTH, default 15, meaning operand 1 width.
REQ-005 The module SHALL have parameter dout_WIDTH, default 29, meaning result and accumulator width.
REQ-006 The module SHALL have parameter din0_SIGNED, default 0, where 1 means din0 is two's complement.
REQ-007 The module SHALL have parameter din1_SIGNED, default 0, where 1 means din1 is two's complement.
REQ-008 The module SHALL have parameter ACC_EN, default 0, where 1 enables multiply-accumulate mode.
REQ-009 Port clk: input, 1 bit, sole clock, rising edge.
REQ-010 Port reset: input, 1 bit, synchronous, active-high.
REQ-011 Port ce: input, 1 bit, global clock enable.
REQ-012 Port vld_in: input, 1 bit, marks din0/din1/acc_clr as valid.
REQ-013 Port acc_clr: input, 1 bit, marks the accumulation restart (ACC_EN=1 only).
REQ-014 Port din0: input, din0_WIDTH bits, operand 0.
REQ-015 Port din1: input, din1_WIDTH bits, operand 1.
REQ-016 Port dout: output, dout_WIDTH bits, product or accumulator value.
REQ-017 Port vld_out: output, 1 bit, high for one ce-enabled cycle per result.

Function
REQ-018 Each operand SHALL be sign-extended when its SIGNED parameter is 1 and zero-extended when it is 0, before multiplication.
REQ-019 The product SHALL be truncated to its low dout_WIDTH bits, with no saturation.
REQ-020 A vld_in sampled at a ce=1 edge SHALL produce vld_out=1 after exactly NUM_STAGE further ce=1 edges, and ce=0 cycles SHALL not count toward that latency.
REQ-021 When ce=0, every pipeline register (data, valid, acc_clr, accumulator, dout) SHALL hold its value, and no sample SHALL be lost or duplicated.
REQ-022 The pipeline SHALL accept a new input on every ce=1 cycle, giving a throughput of one result per ce-enabled cycle.
REQ-023 Cycles with vld_in=0 SHALL propagate bubbles and SHALL never update dout or the accumulator.
REQ-024 When ACC_EN=0, dout SHALL equal the truncated product, and dout SHALL hold its last value while vld_out=0.
REQ-025 When ACC_EN=1, acc_clr SHALL travel down the pipeline with its data.
REQ-026 When ACC_EN=1 and a valid result reaches the final stage, the accumulator SHALL load the product if its acc_clr=1, and otherwise SHALL become accumulator + product modulo 2^dout_WIDTH.
REQ-027 When ACC_EN=1, dout SHALL equal the accumulator.
REQ-028 Accumulation SHALL occur within the final stage and SHALL add no extra latency.
REQ-029 acc_clr SHALL be ignored when vld_in=0 or when ACC_EN=0.
REQ-030 The accumulator SHALL wrap on overflow with no flag.

Reset
REQ-031 When reset=1 at a clk edge, all valid bits, the in-flight acc_clr bits, the accumulator, and dout SHALL clear to 0, and vld_out SHALL be 0.
REQ-032 Reset SHALL take priority over ce: reset=1 clears the pipeline even when ce=0.
REQ-033 Reset asserted mid-operation SHALL discard every in-flight sample, and no vld_out SHALL occur for any sample accepted before the reset.
REQ-034 Operand data registers are not required to reset, but the bench SHALL observe no X on dout after reset.

Structure
REQ-035 Package adpcm_mul_pkg SHALL hold the default-width constants and the NUM_STAGE legal-range constants.
REQ-036 Package adpcm_mul_pkg SHALL hold an operand-extension function parameterised by signedness.
REQ-037 A single sub-module adpcm_main_mul_sreg SHALL implement the ce-gated, synchronously reset delay line for the valid and acc_clr bits, parameterised by depth.
REQ-038 The multiplier datapath SHALL be registered at the input stage and the output stage, with the remaining NUM_STAGE-2 stages retiming the product, and SHALL be a single register when NUM_STAGE=1.
REQ-039 An elaboration-time check SHALL reject NUM_STAGE outside 1..6 and SHALL reject dout_WIDTH < 2.

Verification
REQ-040 Unsigned truncation, defaults: din0=0x7FFF, din1=0x7FFF, vld_in=1 for one cycle, ce=1 -> vld_out=1 three cycles later, with dout=0x1FFF0001.
REQ-041 Signed operands (din0_SIGNED=din1_SIGNED=1): din0=0x7FFF (-1), din1=0x0003 -> dout=0x1FFFFFFD (-3).
REQ-042 Stall: four back-to-back products 1*1, 2*2, 3*3, 4*4, with ce=0 for 2 cycles after the second -> outputs 1, 4, 9, 16 in order, exactly one vld_out each, the last appearing 2 cycles later than unstalled.
REQ-043 MAC (ACC_EN=1): 2*3 with acc_clr=1, then 4*5, then 10*10 -> dout sequence 6, 26, 126, followed by 1*1 with acc_clr=1 -> dout 1.
REQ-044 Accumulator wrap (ACC_EN=1): accumulator at 0x1FFFFFFF, then 1*1 with acc_clr=0 -> dout=0x00000000.
REQ-045 Mid-stream reset: two samples in flight, reset=1 for one cycle -> no vld_out for either sample, dout=0, and the next input 5*7 gives dout=35 after three cycles.
